// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with registered read data; FIFO_SYNC_STATUS_EN adds fill_level/overflow/underflow
module fifo_sync #(
    parameter int   FIFO_DEPTH = 8,
    parameter int   DATA_WIDTH = 32,
    localparam int  AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_SYNC_STATUS_EN
    ,
    output logic [AW:0]           fill_level,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_fire, rd_fire;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_fire  = cs & wr_en & ~full;
    assign rd_fire  = cs & rd_en & ~empty;
    assign data_out = data_out_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not cleared by reset; reset only blocks a same-cycle write
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

`ifdef FIFO_SYNC_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    always_comb begin
        overflow_d  = cs & wr_en & full;
        underflow_d = cs & rd_en & empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - scoreboard bench for fifo_sync (depth 8, width 32)
module tb_fifo_sync;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_SYNC_STATUS_EN
    logic [3:0]    fill_level;
    logic          overflow;
    logic          underflow;
`endif

    fifo_sync #(.FIFO_DEPTH(8), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef FIFO_SYNC_STATUS_EN
        ,
        .fill_level (fill_level),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q [$];
    logic          exp_fire = 1'b0;
    logic          fire_seen = 1'b0;
    logic          rst_seen = 1'b0;
    logic          mon_en = 1'b0;
    logic [DW-1:0] last_exp = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        fire_seen <= exp_fire;
        rst_seen  <= !rst_n;
    end

    // Monitor: data_out must show the next queued word after an expected read, else hold
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                last_exp = '0;
            end else if (fire_seen) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underrun: read seen with no expected word at %0t", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                end
            end
            check("data_out", data_out, last_exp);
        end
    end

    task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] din,
                        input logic ef, input logic [DW-1:0] ev,
                        input logic ee, input logic efl, input logic eo, input logic eu);
        cs = c; wr_en = w; rd_en = r; data_in = din; exp_fire = ef;
        if (ef) exp_q.push_back(ev);
        @(posedge clk);
        #1;
        check("empty", {31'b0, empty}, {31'b0, ee});
        check("full", {31'b0, full}, {31'b0, efl});
`ifdef FIFO_SYNC_STATUS_EN
        check("overflow", {31'b0, overflow}, {31'b0, eo});
        check("underflow", {31'b0, underflow}, {31'b0, eu});
`else
        if (eo || eu) checks += 0;
`endif
        @(negedge clk);
        exp_fire = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hDEAD; exp_fire = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // three writes then three reads
        step(1, 1, 0, 1,   0, 0,   0, 0, 0, 0);
        step(1, 1, 0, 10,  0, 0,   0, 0, 0, 0);
        step(1, 1, 0, 100, 0, 0,   0, 0, 0, 0);
        step(1, 0, 1, 0,   1, 1,   0, 0, 0, 0);
        step(1, 0, 1, 0,   1, 10,  0, 0, 0, 0);
        step(1, 0, 1, 0,   1, 100, 1, 0, 0, 0);

        // alternating write/read, pointers wrap
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 32'd1 << i, 0, 0,          0, 0, 0, 0);
            step(1, 0, 1, 0,          1, 32'd1 << i, 1, 0, 0, 0);
        end

        // fill past full; ninth write dropped
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 0, 32'd1 << i, 0, 0, 0, (i >= 7), (i == 8), 0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, 1, 32'd1 << i, (i == 7), 0, 0, 0);
        end

        // read while empty, then strobes with cs low
        step(1, 0, 1, 0,  0, 0, 1, 0, 0, 1);
        step(0, 1, 1, 55, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0,  0, 0, 1, 0, 0, 0);

        // simultaneous write+read at occupancy 4
        for (int i = 0; i < 4; i++) step(1, 1, 0, 11 + i, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 15, 1, 11, 0, 0, 0, 0);
        step(1, 0, 1, 0,  1, 12, 0, 0, 0, 0);
        step(1, 0, 1, 0,  1, 13, 0, 0, 0, 0);
        step(1, 0, 1, 0,  1, 14, 0, 0, 0, 0);
        step(1, 0, 1, 0,  1, 15, 1, 0, 0, 0);

        // simultaneous when full: write dropped, oldest read
        for (int i = 0; i < 8; i++) step(1, 1, 0, 20 + i, 0, 0, 0, (i == 7), 0, 0);
        step(1, 1, 1, 99, 1, 20, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) step(1, 0, 1, 0, 1, 20 + i, (i == 7), 0, 0, 0);

        // simultaneous when empty: only the write fires
        step(1, 1, 1, 77, 0, 0,  0, 0, 0, 1);
        step(1, 0, 1, 0,  1, 77, 1, 0, 0, 0);

        // reset mid-operation discards contents
        step(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 7, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
